bw_io_impctl_updn_cal: RTL and testbench

Multi-channel impedance-calibration tracker for the DDR I/O impedance controller. Each channel samples an asynchronous comparator output ("pad above reference") on a slow asynchronous sample strobe. It majority-filters the samples and steps a saturating CW-bit drive code up or down. It declares lock once the code dithers around the reference. Replaces the single-bit hold/sample comparator flop with a parametrised up/down calibration engine that drives `cbu`/`cbd`-style code buses directly.

---
 rtl/bw_io_impctl_updn_cal.sv | 153 +++++++++++++++
 tb/tb_bw_io_impctl_updn_cal.sv | 169 ++++++++++++++++
 2 files changed

// File: rtl/bw_io_impctl_updn_cal.sv
// ---------------------------------------------------------------------------
// bw_io_impctl_updn_cal
//
// Multi-channel impedance-calibration tracker. Each channel majority-filters
// an asynchronous comparator ("pad above reference") sampled on a slow
// asynchronous strobe. It steps a saturating drive code up or down, and it
// declares lock once the code dithers around the reference.
//
// Ports:
//   clk           core clock, all state on rising edge
//   global_reset  asynchronous active-high reset
//   sclk          asynchronous sample strobe (one sample per rising edge)
//   above[NCH]    asynchronous comparator outputs, 1 = pad above reference
//   start         synchronous pulse, (re)starts calibration on all channels
//   hold          level, discards sample strobes while high
//   code[NCH*CW]  drive codes, channel i at [i*CW +: CW]
//   lock[NCH]     per-channel lock flag
//   busy          1 while any channel is in TRACK
// ---------------------------------------------------------------------------
module bw_io_impctl_updn_cal #(
    parameter int              NCH       = 2,
    parameter int              CW        = 8,
    parameter int              FILT      = 4,
    parameter int              LOCK_CNT  = 3,
    parameter logic [CW-1:0]   CODE_INIT = CW'(8'h80)
) (
    input  logic                clk,
    input  logic                global_reset,
    input  logic                sclk,
    input  logic [NCH-1:0]      above,
    input  logic                start,
    input  logic                hold,
    output logic [NCH*CW-1:0]   code,
    output logic [NCH-1:0]      lock,
    output logic                busy
);

    localparam int VW = $clog2(FILT) + 2;     // signed vote spans -FILT..+FILT
    localparam int SW = $clog2(FILT) + 1;
    localparam int RW = $clog2(LOCK_CNT + 1);

    typedef enum logic [1:0] {IDLE, TRACK, LOCKED} state_t;
    typedef enum logic [1:0] {D_NONE, D_UP, D_DN}  dir_t;

    logic           sclk_s1, sclk_s2, sclk_s3;
    logic [NCH-1:0] above_s1, above_s2;
    logic           accept;
    logic [NCH-1:0] track;

    // Two-flop synchronizers; a third sclk flop gives a one-cycle rising-edge pulse.
    // NOTE: sequential state uses non-blocking (<=) so every flop samples
    // pre-edge values regardless of statement order.
    always_ff @(posedge clk or posedge global_reset) begin
        if (global_reset) begin
            sclk_s1  <= 1'b0;
            sclk_s2  <= 1'b0;
            sclk_s3  <= 1'b0;
            above_s1 <= '0;
            above_s2 <= '0;
        end else begin
            sclk_s1  <= sclk;
            sclk_s2  <= sclk_s1;
            sclk_s3  <= sclk_s2;
            above_s1 <= above;
            above_s2 <= above_s1;
        end
    end

    assign accept = sclk_s2 & ~sclk_s3 & ~hold;
    assign busy   = |track;

    for (genvar i = 0; i < NCH; i++) begin : g_ch
        state_t                state_q;
        dir_t                  last_q, dir;
        logic [CW-1:0]         code_q;
        logic signed [VW-1:0]  vote_q, vote_nxt;
        logic [SW-1:0]         scnt_q;
        logic [RW-1:0]         rev_q, rev_nxt;
        logic                  lock_q, track_q, last_win;

        // NOTE: every always_comb output gets a default first, so no path
        // can leave it unassigned and infer a latch.
        always_comb begin
            vote_nxt = vote_q + (above_s2[i] ? VW'(1) : {VW{1'b1}});
            last_win = (scnt_q == SW'(FILT - 1));
            dir      = D_NONE;
            if (vote_nxt > 0)      dir = D_UP;
            else if (vote_nxt < 0) dir = D_DN;
            // The first step after start has no reference direction, so
            // the reversal count is left alone.
            rev_nxt = rev_q;
            if (dir != D_NONE && last_q != D_NONE) begin
                if (dir != last_q)
                    rev_nxt = (rev_q < RW'(LOCK_CNT)) ? rev_q + RW'(1) : rev_q;
                else
                    rev_nxt = '0;
            end
        end

        always_ff @(posedge clk or posedge global_reset) begin
            if (global_reset) begin
                state_q <= IDLE;
                code_q  <= CODE_INIT;
                vote_q  <= '0;
                scnt_q  <= '0;
                rev_q   <= '0;
                last_q  <= D_NONE;
                lock_q  <= 1'b0;
                track_q <= 1'b0;
            end else if (start) begin
                // start also discards any decision landing on this edge
                state_q <= TRACK;
                code_q  <= CODE_INIT;
                vote_q  <= '0;
                scnt_q  <= '0;
                rev_q   <= '0;
                last_q  <= D_NONE;
                lock_q  <= 1'b0;
                track_q <= 1'b1;
            end else if (accept && state_q != IDLE) begin
                if (!last_win) begin
                    scnt_q <= scnt_q + SW'(1);
                    vote_q <= vote_nxt;
                end else begin
                    scnt_q <= '0;
                    vote_q <= '0;
                    if (dir != D_NONE) begin
                        // A saturated step still updates direction tracking.
                        if (dir == D_UP && code_q != {CW{1'b1}}) code_q <= code_q + CW'(1);
                        if (dir == D_DN && code_q != '0)         code_q <= code_q - CW'(1);
                        last_q <= dir;
                        rev_q  <= rev_nxt;
                        if (state_q == TRACK && rev_nxt >= RW'(LOCK_CNT)) begin
                            state_q <= LOCKED;
                            lock_q  <= 1'b1;
                            track_q <= 1'b0;
                        end else if (state_q == LOCKED && dir == last_q) begin
                            state_q <= TRACK;
                            lock_q  <= 1'b0;
                            track_q <= 1'b1;
                            rev_q   <= '0;
                        end
                    end
                end
            end
        end

        assign code[i*CW +: CW] = code_q;
        assign lock[i]          = lock_q;
        assign track[i]         = track_q;
    end

endmodule

// File: tb/tb_bw_io_impctl_updn_cal.sv
// ---------------------------------------------------------------------------
// tb_bw_io_impctl_updn_cal
//
// Directed, table-driven bench for bw_io_impctl_updn_cal. A second instance
// with CODE_INIT = 0xFE shares the stimulus to exercise upper saturation.
// ---------------------------------------------------------------------------
module tb_bw_io_impctl_updn_cal;

    logic        clk = 1'b0;
    logic        global_reset;
    logic        sclk;
    logic [1:0]  above;
    logic        start;
    logic        hold;
    logic [15:0] code, code2;
    logic [1:0]  lock, lock2;
    logic        busy, busy2;

    int pass_cnt  = 0;
    int total_cnt = 0;

    always #5 clk = ~clk;

    bw_io_impctl_updn_cal dut (
        .clk(clk), .global_reset(global_reset), .sclk(sclk), .above(above),
        .start(start), .hold(hold), .code(code), .lock(lock), .busy(busy)
    );

    bw_io_impctl_updn_cal #(.CODE_INIT(8'hFE)) dut_sat (
        .clk(clk), .global_reset(global_reset), .sclk(sclk), .above(above),
        .start(start), .hold(hold), .code(code2), .lock(lock2), .busy(busy2)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total_cnt++;
        if (act === exp) pass_cnt++;
        else $display("FAIL %s: got %h, expected %h", name, act, exp);
    endtask

    // n sclk pulses, 4 clk high / 4 clk low; ends on a falling clk edge
    task automatic pulses(input int n);
        for (int k = 0; k < n; k++) begin
            @(negedge clk) sclk = 1'b1;
            repeat (4) @(negedge clk);
            sclk = 1'b0;
            repeat (3) @(negedge clk);
        end
    endtask

    task automatic do_start();
        @(negedge clk) start = 1'b1;
        @(negedge clk) start = 1'b0;
    endtask

    typedef struct {
        logic [1:0]  ab;
        logic        hd;
        logic [15:0] exp_code;   // {ch1, ch0}
        logic [1:0]  exp_lock;
        logic        exp_busy;
    } vec_t;

    vec_t vecs[9];

    initial begin
        // Each entry is one full 4-sample window following a start.
        vecs[0] = '{2'b01, 1'b0, 16'h7F81, 2'b00, 1'b1};
        vecs[1] = '{2'b01, 1'b0, 16'h7E82, 2'b00, 1'b1};
        vecs[2] = '{2'b01, 1'b0, 16'h7D83, 2'b00, 1'b1};
        vecs[3] = '{2'b10, 1'b0, 16'h7E82, 2'b00, 1'b1};  // reversal 1
        vecs[4] = '{2'b01, 1'b0, 16'h7D83, 2'b00, 1'b1};  // reversal 2
        vecs[5] = '{2'b10, 1'b0, 16'h7E82, 2'b11, 1'b0};  // reversal 3 -> lock
        vecs[6] = '{2'b00, 1'b0, 16'h7D81, 2'b10, 1'b1};  // ch0 repeats DN -> unlock
        vecs[7] = '{2'b00, 1'b0, 16'h7C80, 2'b00, 1'b1};  // ch1 repeats DN -> unlock
        vecs[8] = '{2'b11, 1'b1, 16'h7C80, 2'b00, 1'b1};  // held window ignored

        global_reset = 1'b1;
        sclk = 1'b0; above = 2'b00; start = 1'b0; hold = 1'b0;
        repeat (3) @(negedge clk);
        check("reset_code", 32'(code), 32'h8080);
        check("reset_lock", 32'(lock), 32'h0);
        check("reset_busy", 32'(busy), 32'h0);
        global_reset = 1'b0;

        // Idle: strobes without start change nothing
        above = 2'b11;
        pulses(4);
        check("idle_code", 32'(code), 32'h8080);
        check("idle_busy", 32'(busy), 32'h0);
        above = 2'b00;
        pulses(4);
        check("idle_code2", 32'(code), 32'h8080);
        check("idle_lock", 32'(lock), 32'h0);

        // Table: monotone track, dither lock, unlock, held window
        do_start();
        check("start_busy", 32'(busy), 32'h1);
        for (int v = 0; v < 9; v++) begin
            above = vecs[v].ab;
            hold  = vecs[v].hd;
            pulses(4);
            hold = 1'b0;
            check($sformatf("vec%0d_code", v), 32'(code), 32'(vecs[v].exp_code));
            check($sformatf("vec%0d_lock", v), 32'(lock), 32'(vecs[v].exp_lock));
            check($sformatf("vec%0d_busy", v), 32'(busy), 32'(vecs[v].exp_busy));
        end

        // Tie and hold mid-window
        do_start();
        above = 2'b11;
        pulses(2);
        hold = 1'b1;
        pulses(3);
        hold = 1'b0;
        check("hold_no_count", 32'(code), 32'h8080);
        above = 2'b00;
        pulses(2);
        check("tie_code", 32'(code), 32'h8080);
        above = 2'b11;
        pulses(4);
        check("after_tie_code", 32'(code), 32'h8181);

        // Saturation at the top
        do_start();
        check("sat_init", 32'(code2), 32'hFEFE);
        above = 2'b11;
        pulses(4);
        check("sat_first", 32'(code2), 32'hFFFF);
        pulses(8);
        check("sat_hold", 32'(code2), 32'hFFFF);
        check("sat_ref_code", 32'(code), 32'h8383);

        // Asynchronous reset mid-window
        do_start();
        pulses(4);
        check("pre_reset_code", 32'(code), 32'h8181);
        pulses(2);
        @(negedge clk) sclk = 1'b1;
        @(negedge clk);
        #2 global_reset = 1'b1;
        #1;
        check("async_rst_code", 32'(code), 32'h8080);
        check("async_rst_busy", 32'(busy), 32'h0);
        check("async_rst_lock", 32'(lock), 32'h0);
        @(negedge clk) global_reset = 1'b0;
        sclk = 1'b0;
        pulses(4);
        check("post_rst_idle", 32'(code), 32'h8080);

        // start on the same edge as a decision: start wins
        do_start();
        above = 2'b11;
        pulses(3);
        @(negedge clk) sclk = 1'b1;   // s1 captures on next edge, decision 3 edges on
        @(negedge clk);
        @(negedge clk) start = 1'b1;
        @(negedge clk) start = 1'b0;
        check("collide_code", 32'(code), 32'h8080);
        check("collide_busy", 32'(busy), 32'h1);
        @(negedge clk) sclk = 1'b0;
        repeat (4) @(negedge clk);
        pulses(4);
        check("collide_next", 32'(code), 32'h8181);

        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
